fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Frame sequencer and stream adapter for the radix-2 SDF FFT core (R2Sdf). It takes a valid/ready sample stream and drives the core's clock-enable, input and in_sync. It returns bit-reversed core output as a valid/ready stream tagged with natural bin index and frame-last. It also zero-pads partial frames on flush, drains the pipeline, and changes scale/inverse configuration only when the pipeline is empty.

Parameters:
STG, 4, FFT stages; frame length N = 2**STG
DW, 16, real/imag sample width
LAT, 20, core latency in en-steps from sample accepted into core_in to its result at core_out; must equal the instantiated core's latency

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_scale  in  1  requested per-stage 1/2 scaling
cfg_inv  in  1  requested inverse transform
flush  in  1  pulse: close current frame and drain
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&&s_ready
s_re, s_im  in  DW each  input sample (signed)
m_valid  out  1  output bin valid
m_ready  in  1  downstream accept
m_re, m_im  out  DW each  output bin
m_idx  out  STG  natural bin index of current output
m_last  out  1  last bin of frame
core_en  out  1  core clock-enable (one en-step)
core_in_re, core_in_im  out  DW each  core input
core_in_sync  out  1  high on the en-step carrying input index N-1
core_scale, core_invexp  out  1 each  latched configuration to core
core_out_re, core_out_im  in  DW each  core output register
core_out_sync  in  1  core marks its output index N-1 (bit-reversed all-ones)
busy  out  1  state != RUN or inflight != 0
sync_err  out  1  sticky alignment error

Behaviour:
- Reset (async):
  - state=RUN; s_cnt, o_cnt and inflight = 0.
  - Tag line cleared.
  - core_scale and core_invexp = 0; sync_err = 0.
  - All outputs low or zero.
- en-step:
  - core_en = in_ok && out_ok.
  - out_ok = !m_valid || m_ready.
  - in_ok = (state==RUN && s_valid && !cfg_hold) || state in {PAD, DRAIN}.
- s_ready = (state==RUN) && !cfg_hold && out_ok.
  - Acceptance therefore coincides exactly with a RUN-state en-step.
- core_in:
  - Equals s_re/s_im in RUN, zeros in PAD and DRAIN.
  - Combinational; the core registers it.
- s_cnt:
  - Increments modulo N on every en-step in any state.
  - core_in_sync = (s_cnt == N-1) && core_en.
- Tag line: LAT-deep shift register, advancing only on en-steps, with one bit per slot.
  - Bit set when the step is a RUN acceptance or a PAD sample.
  - Bit clear for DRAIN samples.
  - m_valid = tag at output position.
  - Because the core output register holds when en is low, m_re/m_im = core_out held stable while stalled.
- inflight (0..LAT):
  - +1 when a set tag enters.
  - -1 when a set tag leaves via an en-step.
  - Net 0 on simultaneous enter and leave.
- o_cnt:
  - Increments modulo N on m_valid && m_ready.
  - m_idx = bit-reverse(o_cnt); m_last = (o_cnt == N-1).
- sync_err:
  - Sets if a valid output with o_cnt==N-1 is consumed on an en-step where core_out_sync is low.
  - Sets if core_out_sync is high on a valid output with o_cnt != N-1.
  - Clears only on reset.
- FSM transitions:
  - RUN -> PAD: flush while s_cnt != 0.
  - RUN -> DRAIN: flush while s_cnt == 0.
  - RUN -> DRAIN: cfg_hold, where cfg_hold = (s_cnt == 0) && ({cfg_scale,cfg_inv} != {core_scale,core_invexp}) && inflight != 0.
  - PAD -> DRAIN: after the en-step with s_cnt == N-1.
  - DRAIN -> RUN: when inflight == 0 && s_cnt == 0. Zeros keep flowing until both hold, which preserves frame phase.
- Config latch:
  - core_scale/core_invexp load cfg_* only when s_cnt == 0 && inflight == 0, in RUN or on the DRAIN->RUN transition.
  - Never loaded mid-frame, nor while frames are in flight.
- Boundary conditions:
  - flush in PAD or DRAIN: ignored.
  - flush with s_cnt == 0 and inflight == 0: enter DRAIN and exit next cycle; no en-steps.
  - s_valid and flush in the same RUN cycle: the sample is accepted, then the transition uses the post-increment s_cnt.
  - m_ready low: core_en is low, the whole pipeline freezes, and no data is lost or duplicated.
  - rst asserted mid-frame: everything is discarded and the next sample starts frame index 0.

Test Plan:
- STG=4, LAT=core latency, scale=1, one frame of all 10000+0j, m_ready=1 -> 16 outputs: m_idx=0 gives 10000+0j, all other bins 0; m_last only on m_idx=15; sync_err=0.
- Impulse frame (x[0]=10000, rest 0), scale=1, then flush -> all 16 bins 625+0j; busy falls after inflight reaches 0; no extra m_valid beyond 16.
- 5 samples of 10000 then flush -> PAD feeds 11 zeros, yielding one complete 16-bin frame; bin 0 = 3125 with scale=1; state ends RUN with s_cnt=0.
- Random m_ready (50%) over 3 back-to-back DC frames -> output values and order identical to the m_ready=1 run; m_re/m_im stable while m_valid && !m_ready.
- cfg_scale toggled 0->1 mid-frame 2 -> frame 2 completes with scale=0; s_ready is low at the frame-3 boundary until drained; core_scale=1 before frame 3's first sample is accepted.
- Force core_out_sync stuck low -> sync_err=1 on the first consumed m_last; rst asserted mid-frame clears all state and outputs asynchronously.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer and valid/ready stream adapter for the R2Sdf FFT core
module fft_frame_ctrl #(
    parameter int STG = 4,
    parameter int DW  = 16,
    parameter int LAT = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_scale,
    input  logic                 cfg_inv,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_re,
    input  logic signed [DW-1:0] s_im,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_re,
    output logic signed [DW-1:0] m_im,
    output logic [STG-1:0]       m_idx,
    output logic                 m_last,
    output logic                 core_en,
    output logic signed [DW-1:0] core_in_re,
    output logic signed [DW-1:0] core_in_im,
    output logic                 core_in_sync,
    output logic                 core_scale,
    output logic                 core_invexp,
    input  logic signed [DW-1:0] core_out_re,
    input  logic signed [DW-1:0] core_out_im,
    input  logic                 core_out_sync,
    output logic                 busy,
    output logic                 sync_err
);

    localparam int IW = $clog2(LAT + 1);
    localparam logic [STG-1:0] LAST = {STG{1'b1}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [STG-1:0] s_cnt, o_cnt, s_cnt_post;
    logic [LAT-1:0] tag;
    logic [IW-1:0]  inflight;
    logic           taken;
    logic           cfg_hold, drain_done, out_ok, in_ok;
    logic           tag_in, tag_out, cfg_load;

    // An output handshake without an en-step leaves the tag in place; taken masks it so it is not seen twice.
    assign m_valid    = tag[LAT-1] && !taken;
    assign out_ok     = !m_valid || m_ready;
    assign drain_done = (inflight == '0) && (s_cnt == '0);
    assign cfg_hold   = (s_cnt == '0) && ({cfg_scale, cfg_inv} != {core_scale, core_invexp})
                        && (inflight != '0);
    assign in_ok      = (state == RUN && s_valid && !cfg_hold) || (state == PAD)
                        || (state == DRAIN && !drain_done);
    assign core_en    = in_ok && out_ok;
    assign s_ready    = (state == RUN) && !cfg_hold && out_ok;

    assign core_in_re   = (state == RUN) ? s_re : '0;
    assign core_in_im   = (state == RUN) ? s_im : '0;
    assign core_in_sync = (s_cnt == LAST) && core_en;

    assign tag_in   = core_en && (state != DRAIN);
    assign tag_out  = core_en && tag[LAT-1];
    assign cfg_load = (s_cnt == '0) && (inflight == '0) && (state == RUN || state == DRAIN);

    assign m_re   = core_out_re;
    assign m_im   = core_out_im;
    assign m_last = (o_cnt == LAST);
    assign busy   = (state != RUN) || (inflight != '0);

    always_comb begin
        m_idx = '0;
        for (int i = 0; i < STG; i++) begin
            m_idx[i] = o_cnt[STG-1-i];
        end
    end

    // A flush in the same cycle as an accepted sample is judged on the post-increment count.
    always_comb begin
        state_nx   = state;
        s_cnt_post = core_en ? s_cnt + 1'b1 : s_cnt;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nx = (s_cnt_post != '0) ? PAD : DRAIN;
                end else if (cfg_hold) begin
                    state_nx = DRAIN;
                end
            end
            PAD: begin
                if (core_en && s_cnt == LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            s_cnt       <= '0;
            o_cnt       <= '0;
            inflight    <= '0;
            tag         <= '0;
            taken       <= 1'b0;
            core_scale  <= 1'b0;
            core_invexp <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (core_en) begin
                s_cnt <= s_cnt + 1'b1;
                tag   <= {tag[LAT-2:0], tag_in};
                taken <= 1'b0;
            end else if (m_valid && m_ready) begin
                taken <= 1'b1;
            end
            if (tag_in && !tag_out) begin
                inflight <= inflight + 1'b1;
            end else if (!tag_in && tag_out) begin
                inflight <= inflight - 1'b1;
            end
            if (m_valid && m_ready) begin
                o_cnt <= o_cnt + 1'b1;
            end
            if (cfg_load) begin
                core_scale  <= cfg_scale;
                core_invexp <= cfg_inv;
            end
            if ((m_valid && m_ready && o_cnt == LAST && !core_out_sync)
                || (m_valid && core_out_sync && o_cnt != LAST)) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - scoreboard bench for fft_frame_ctrl with a behavioural FFT core stand-in
module tb_fft_frame_ctrl;

    localparam int STG = 4;
    localparam int DW  = 16;
    localparam int LAT = 20;
    localparam int N   = 1 << STG;
    localparam int MEM = 4096;
    localparam int FR  = MEM / N;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst, cfg_scale, cfg_inv, flush, s_valid, s_ready, m_valid, m_ready, m_last;
    logic signed [DW-1:0] s_re, s_im, m_re, m_im, core_in_re, core_in_im, core_out_re, core_out_im;
    logic [STG-1:0] m_idx;
    logic core_en, core_in_sync, core_scale, core_invexp, core_out_sync, busy, sync_err;
    logic core_out_sync_m;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.STG(STG), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cfg_scale(cfg_scale), .cfg_inv(cfg_inv), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_idx(m_idx), .m_last(m_last), .core_en(core_en),
        .core_in_re(core_in_re), .core_in_im(core_in_im), .core_in_sync(core_in_sync),
        .core_scale(core_scale), .core_invexp(core_invexp),
        .core_out_re(core_out_re), .core_out_im(core_out_im), .core_out_sync(core_out_sync),
        .busy(busy), .sync_err(sync_err)
    );

    int  checks = 0;
    int  failures = 0;
    bit  force_sync = 0;
    bit  rand_ready = 0;
    bit  sync_exp = 0;
    int  acc_wait;
    logic acc_scale;

    typedef struct {
        int re;
        int im;
        int idx;
        bit last;
        bit chk;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < STG; i++) begin
            if (v[i]) r |= 1 << (STG - 1 - i);
        end
        return r;
    endfunction

    // Behavioural core: exact DFT per frame, bins emitted in bit-reversed order LAT en-steps after input.
    int in_re[0:MEM-1];
    int in_im[0:MEM-1];
    bit fr_scale[0:FR-1];
    bit fr_inv[0:FR-1];
    int ec;
    int cr, ci;

    function automatic int rnd(input real x);
        return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    endfunction

    function automatic void calc(input int k, output int ore, output int oim);
        int f, b;
        real sr, si, ang, xr, xi;
        f = k / N;
        b = bitrev(k % N);
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < N; n++) begin
            xr  = in_re[(f * N + n) % MEM];
            xi  = in_im[(f * N + n) % MEM];
            ang = (fr_inv[f % FR] ? 2.0 : -2.0) * PI * n * b / N;
            sr += xr * $cos(ang) - xi * $sin(ang);
            si += xr * $sin(ang) + xi * $cos(ang);
        end
        if (fr_scale[f % FR]) begin
            sr = sr / N;
            si = si / N;
        end
        ore = rnd(sr);
        oim = rnd(si);
    endfunction

    assign core_out_sync = core_out_sync_m && !force_sync;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ec = 0;
            core_out_re     <= '0;
            core_out_im     <= '0;
            core_out_sync_m <= 1'b0;
        end else if (core_en) begin
            in_re[ec % MEM] = int'(core_in_re);
            in_im[ec % MEM] = int'(core_in_im);
            if (core_in_sync) begin
                fr_scale[(ec / N) % FR] = core_scale;
                fr_inv[(ec / N) % FR]   = core_invexp;
            end
            if (ec >= LAT - 1) begin
                calc(ec - LAT + 1, cr, ci);
                core_out_re     <= DW'(cr);
                core_out_im     <= DW'(ci);
                core_out_sync_m <= ((ec - LAT + 1) % N == N - 1);
            end
            ec = ec + 1;
        end
    end

    // Monitor: pops on each consumed output and checks held data while stalled.
    bit hold = 0;
    logic signed [DW-1:0] h_re, h_im;
    logic [STG-1:0] h_idx;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (m_valid && hold) begin
                chk("hold_re", m_re, h_re);
                chk("hold_im", m_im, h_im);
                chk("hold_idx", m_idx, h_idx);
            end
            if (m_valid && m_ready) begin
                hold = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_idx", m_idx, e.idx);
                    chk("m_last", m_last, e.last);
                    if (e.chk) begin
                        chk("m_re", m_re, e.re);
                        chk("m_im", m_im, e.im);
                    end
                    chk("sync_err_live", sync_err, sync_exp);
                    if (m_last && force_sync) sync_exp = 1;
                end
            end else if (m_valid) begin
                hold  = 1;
                h_re  = m_re;
                h_im  = m_im;
                h_idx = m_idx;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push_frame(input int b0, input int rest, input bit chk_rest);
        exp_t x;
        for (int o = 0; o < N; o++) begin
            x.idx  = bitrev(o);
            x.last = (o == N - 1);
            x.re   = (x.idx == 0) ? b0 : rest;
            x.im   = 0;
            x.chk  = (x.idx == 0) || chk_rest;
            exp_q.push_back(x);
        end
    endtask

    task automatic send_sample(input int re, input int im);
        bit ok = 0;
        s_re    = DW'(re);
        s_im    = DW'(im);
        s_valid = 1'b1;
        acc_wait = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                acc_scale = core_scale;
                break;
            end
            acc_wait++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_vals(input int n, input int v0, input int vrest);
        for (int i = 0; i < n; i++) send_sample(i == 0 ? v0 : vrest, 0);
    endtask

    task automatic do_flush();
        s_valid = 1'b0;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_idle"}, ok, 1);
        repeat (4) @(negedge clk);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_sync_err"}, sync_err, sync_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_scale = 1'b1; cfg_inv = 1'b0; flush = 1'b0;
        s_valid = 1'b0; s_re = '0; s_im = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_core_scale", core_scale, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cfg_latch_idle", core_scale, 1);

        // empty flush: one DRAIN cycle, no en-steps
        do_flush();
        @(negedge clk);
        chk("empty_flush_busy", busy, 1);
        chk("empty_flush_en", core_en, 0);
        @(negedge clk);
        chk("empty_flush_exit", busy, 0);
        @(posedge clk);
        #1;

        // DC frame 10000 scaled: bin 0 = 10000, rest 0
        push_frame(10000, 0, 1);
        send_vals(N, 10000, 10000);
        do_flush();
        wait_idle("dc");

        // impulse: all bins 625
        push_frame(625, 625, 1);
        send_vals(N, 10000, 0);
        do_flush();
        wait_idle("impulse");

        // partial frame padded with 11 zeros: bin 0 = 3125
        push_frame(3125, 0, 0);
        send_vals(5, 10000, 10000);
        do_flush();
        wait_idle("pad");

        // three back-to-back frames under random backpressure
        push_frame(1000, 0, 1);
        push_frame(2000, 0, 1);
        push_frame(3000, 0, 1);
        rand_ready = 1;
        send_vals(N, 1000, 1000);
        send_vals(N, 2000, 2000);
        send_vals(N, 3000, 3000);
        do_flush();
        wait_idle("backpressure");
        rand_ready = 0;

        // config change mid-frame: applies only after the pipeline drains
        cfg_scale = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cfg_latch_zero", core_scale, 0);
        push_frame(1600, 0, 1);
        push_frame(100, 0, 1);
        for (int i = 0; i < N; i++) begin
            send_sample(100, 0);
            if (i == 7) cfg_scale = 1'b1;
        end
        chk("cfg_no_midframe", core_scale, 0);
        send_sample(100, 0);
        chk("cfg_boundary_stall", acc_wait > 0, 1);
        chk("cfg_applied_first", acc_scale, 1);
        send_vals(N - 1, 100, 100);
        do_flush();
        wait_idle("cfg");

        // core_out_sync stuck low: sync_err on the first consumed m_last
        force_sync = 1;
        push_frame(10000, 0, 1);
        send_vals(N, 10000, 10000);
        do_flush();
        wait_idle("stuck_sync");
        chk("stuck_sync_err", sync_err, 1);
        force_sync = 0;

        // asynchronous reset mid-frame with outputs in flight
        push_frame(500, 0, 1);
        send_vals(N + 7, 500, 500);
        s_valid = 1'b0;
        chk("pre_rst_valid", m_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sync_err", sync_err, 0);
        chk("arst_core_scale", core_scale, 0);
        chk("arst_core_sync", core_in_sync, 0);
        exp_q.delete();
        sync_exp = 0;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_frame(10000, 0, 1);
        send_vals(N, 10000, 10000);
        do_flush();
        wait_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
